// File: rtl/sample_serializer_pkg.sv
// Shared types and constants for the sample readout serializer.
// Build option: SAMPLE_SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
package sample_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        GAP      = 2'd3
    } ser_state_t;

    localparam int DATA_W_DEF     = 12;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int SCLK_DIV_DEF   = 4;

`ifdef SAMPLE_SERIALIZER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam int FRAME_LEN = DATA_W_DEF + PARITY_BITS;

    // Bits per serial frame for a given sample width.
    function automatic int frame_len(input int data_w);
        return data_w + PARITY_BITS;
    endfunction

endpackage

// File: rtl/sample_serializer_if.sv
// Decimator-side sample input and pad-side serial outputs of the serializer.
// master: the sample source / observer; slave: the serializer itself.
interface sample_serializer_if
    import sample_serializer_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] data_in;
    logic              new_data;
    logic              cs_n;
    logic              sclk;
    logic              sdo;
    logic              busy;
    logic              overflow;
    logic [LVL_W-1:0]  fifo_level;

    modport master (
        output data_in, new_data,
        input  cs_n, sclk, sdo, busy, overflow, fifo_level
    );

    modport slave (
        input  data_in, new_data,
        output cs_n, sclk, sdo, busy, overflow, fifo_level
    );
endinterface

// File: rtl/sample_serializer_fifo.sv
// Small synchronous FIFO (module sync_fifo). A push is accepted when full only
// if a pop happens in the same cycle. Head word is presented combinationally.
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end
endmodule

// File: rtl/sample_serializer.sv
// Sample readout serializer: buffers strobed samples and shifts them MSB-first
// over cs_n/sclk/sdo. Build option SAMPLE_SERIALIZER_PARITY_EN adds a trailing
// even-parity bit per frame.
//
// state    | meaning
// IDLE     | link quiet; pops the FIFO head when one is available
// SHIFT_LO | cs_n low, sclk low, current bit driven on sdo
// SHIFT_HI | sclk high, sdo held for the receiver to sample
// GAP      | cs_n high spacing between frames
module sample_serializer
    import sample_serializer_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int SCLK_DIV   = SCLK_DIV_DEF
) (
    input  logic                clk,
    input  logic                rst,
    sample_serializer_if.slave  bus
);
    localparam int N     = frame_len(DATA_W);
    localparam int CNT_W = $clog2(N + 1);
    localparam int DIV_W = $clog2(SCLK_DIV + 1);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(SCLK_DIV - 1);

    ser_state_t        state;
    logic [N-2:0]      shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic              cs_n_q;
    logic              sclk_q;
    logic              sdo_q;
    logic              busy_q;
    logic              overflow_q;

    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LVL_W-1:0]  fifo_lvl;
    logic              pop;
    logic [N-1:0]      frame_word;

    assign pop = (state == IDLE) && !fifo_empty;

`ifdef SAMPLE_SERIALIZER_PARITY_EN
    assign frame_word = {fifo_dout, ^fifo_dout};
`else
    assign frame_word = fifo_dout;
`endif

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.new_data),
        .push_data (bus.data_in),
        .pop       (pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_lvl)
    );

    // Dropped-sample flag: strobe while full and nothing leaving this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= bus.new_data && fifo_full && !pop;
        end
    end

    // Frame sequencer with registered link outputs.
    // The MSB goes straight to sdo on load; shreg keeps only the remaining bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        shreg   <= frame_word[N-2:0];
                        bit_cnt <= CNT_W'(N);
                        div_cnt <= DIV_LOAD;
                        state   <= SHIFT_LO;
                        cs_n_q  <= 1'b0;
                        sclk_q  <= 1'b0;
                        sdo_q   <= frame_word[N-1];
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT_LO: begin
                    if (div_cnt == '0) begin
                        div_cnt <= DIV_LOAD;
                        state   <= SHIFT_HI;
                        sclk_q  <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                SHIFT_HI: begin
                    if (div_cnt == '0) begin
                        div_cnt <= DIV_LOAD;
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt - CNT_W'(1);
                        sclk_q  <= 1'b0;
                        if (bit_cnt == CNT_W'(1)) begin
                            state  <= GAP;
                            cs_n_q <= 1'b1;
                            sdo_q  <= 1'b0;
                        end else begin
                            state <= SHIFT_LO;
                            sdo_q <= shreg[N-2];
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                GAP: begin
                    if (div_cnt == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt - DIV_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cs_n       = cs_n_q;
    assign bus.sclk       = sclk_q;
    assign bus.sdo        = sdo_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_level = fifo_lvl;
endmodule

// File: doc/sample_serializer.md
# sample_serializer

Readout end of the decimated-sample path. Accepts 12-bit words qualified by a one-cycle `new_data` strobe from the decimator and buffers them in a small FIFO. Shifts each word off-chip MSB-first over a 3-wire SPI-style link (`cs_n`, `sclk`, `sdo`). Sits between the decimator output and the chip pads.

## Interface
- `DATA_W`, 12: sample width.
- `FIFO_DEPTH`, 4: buffered samples; power of 2, ≥2.
- `SCLK_DIV`, 4: clk cycles per `sclk` half-period; ≥1.

- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_in`  in  DATA_W  sample, valid only when `new_data`=1.
- `new_data`  in  1  one-cycle write strobe.
- `cs_n`  out  1  frame select, active-low.
- `sclk`  out  1  serial clock, idle low.
- `sdo`  out  1  serial data; the receiver samples it on the `sclk` rising edge.
- `busy`  out  1  high while the FSM is not in IDLE.
- `overflow`  out  1  one-cycle pulse when a sample is dropped.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- FIFO write: on `new_data`=1, if not full, or if full with a pop in the same cycle, push `data_in`. Otherwise drop the sample and pulse `overflow` the next cycle.
- Frame length N = DATA_W (DATA_W+1 with parity).
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and load the bit counter with N, then go to SHIFT_LO. No fall-through: a word written this cycle is not visible until the next cycle.
  - SHIFT_LO: `cs_n`=0, `sclk`=0, `sdo`=current MSB. After SCLK_DIV cycles, go to SHIFT_HI.
  - SHIFT_HI: `sclk`=1, `sdo` held. After SCLK_DIV cycles, shift left and decrement the counter. If the counter reaches 0, go to GAP; otherwise go to SHIFT_LO.
  - GAP: `cs_n`=1, `sclk`=0, `sdo`=0. After SCLK_DIV cycles, go to IDLE.
- `sdo` changes only while `sclk`=0. It is 0 outside SHIFT_LO/SHIFT_HI.
- `busy`=1 in SHIFT_LO, SHIFT_HI and GAP.

## Timing
- Reset values: `cs_n`=1, `sclk`=0, `sdo`=0, `busy`=0, `overflow`=0, `fifo_level`=0. FSM in IDLE, FIFO empty, counters 0.
- Latency when idle and empty:
  - `new_data` at cycle T.
  - `fifo_level`=1 at T+1.
  - Pop at T+1.
  - `cs_n`=0 with the first bit on `sdo` at T+2.
- `cs_n` low for exactly 2·N·SCLK_DIV cycles.
- Frame period, back-to-back: 1 + 2·N·SCLK_DIV + SCLK_DIV cycles (101 at defaults). This must stay below the decimation period of 512.
- All outputs are registered.
- Reset mid-frame: on the cycle after `rst` is sampled high, every output is at its reset value and the FIFO contents are discarded. No partial frame resumes.
- `new_data` during reset is ignored.

## Configuration
- `SAMPLE_SERIALIZER_PARITY_EN`:
  - Defined: N = DATA_W+1. One extra bit, the even parity (XOR of all data bits), is sent after the LSB.
  - Undefined: N = DATA_W, no parity logic.

## Structure
- Package `sample_serializer_pkg` holds:
  - the state enum (IDLE, SHIFT_LO, SHIFT_HI, GAP);
  - the default widths;
  - the frame-length constant selected by the macro.
- Sub-module `sync_fifo`, parameterised by width and depth. It has push/pop/full/empty/level, same-cycle push+pop when full, and synchronous active-high reset.
- Top level holds the FSM, shift register, bit counter, divider counter and overflow logic.

## Test plan
- SCLK_DIV=1, single `data_in`=0xA5C → `cs_n` low 24 cycles; `sdo` on rising `sclk` edges = 1010_0101_1100; then `cs_n` high for 1 cycle; `busy` falls.
- Defaults, 3 strobes spaced 600 cycles, values 0x001/0x800/0xFFF → three 96-cycle frames with the correct bits; `fifo_level` never exceeds 1.
- Defaults, 6 strobes on consecutive cycles (0x100..0x105) → 0x100 is popped before the 6th push, so 0x100–0x104 are accepted and 0x105 is dropped with one `overflow` pulse; frames 0x100–0x104 follow in order.
- FIFO full with a pop in the same cycle as `new_data` → sample accepted, `fifo_level` unchanged, no `overflow`.
- `rst` asserted at bit 5 of a frame → next cycle `cs_n`=1, `sclk`=0, `sdo`=0, `fifo_level`=0. A fresh strobe afterwards yields a complete, correct frame.
- Parity enabled, `data_in`=0x001 → 13 bits, last bit 1. `data_in`=0xA5C → last bit 0.
